// File: rtl/mc_multiport.sv
// Multi-port byte-serial memory controller: arbitrates NUM_PORTS requesters onto one
// 8-bit RAM bus and moves 0..MAX_LEN little-endian bytes per grant.
module mc_multiport #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int MAX_LEN   = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        re,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*32-1:0]     w_data,
  input  logic [NUM_PORTS*3-1:0]      len_in_byte,
  output logic [NUM_PORTS*32-1:0]     r_data,
  output logic [NUM_PORTS-1:0]        state_busy,
  output logic [NUM_PORTS-1:0]        state_done,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int KW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     grant_q, ptr_q, winner;
  logic              found;
  logic [ADDR_W-1:0] base_q, last_a_q, cur_a;
  logic [31:0]       wdata_q;
  logic [KW-1:0]     len_q, k_q, win_len;
  logic [2:0]        raw_len;
  logic              wr_q;
  logic [31:0]       rdata_q [NUM_PORTS];

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      int idx;
      idx = (ARB_MODE == 1) ? (int'(ptr_q) + 1 + o) % NUM_PORTS : o;
      if (!found && (re[idx] || we[idx])) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign raw_len = len_in_byte[int'(winner)*3 +: 3];
  assign win_len = (int'(raw_len) > MAX_LEN) ? KW'(MAX_LEN) : KW'(raw_len);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = (win_len == '0) ? DONE : ISSUE;
      ISSUE:   if (k_q == len_q - 1'b1) state_d = wr_q ? DONE : DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= PW'(NUM_PORTS - 1);
      base_q   <= '0;
      last_a_q <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      k_q      <= '0;
      wr_q     <= 1'b0;
      // NOTE: the read-data array is reset because it drives outputs that must read zero after reset.
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (found) begin
          grant_q         <= winner;
          ptr_q           <= winner;
          base_q          <= addr[int'(winner)*ADDR_W +: ADDR_W];
          wdata_q         <= w_data[int'(winner)*32 +: 32];
          len_q           <= win_len;
          wr_q            <= we[winner];
          k_q             <= '0;
          rdata_q[winner] <= '0;
        end
        ISSUE: begin
          last_a_q <= cur_a;
          k_q      <= k_q + 1'b1;
          // The byte addressed in the previous cycle arrives now.
          if (!wr_q && k_q != '0) rdata_q[grant_q][8*(int'(k_q)-1) +: 8] <= mem_din;
        end
        DRAIN:   rdata_q[grant_q][8*(int'(k_q)-1) +: 8] <= mem_din;
        default: ;
      endcase
    end
  end

  assign cur_a    = base_q + ADDR_W'(k_q);
  assign mem_a    = (state_q == ISSUE) ? cur_a : last_a_q;
  assign mem_wr   = rdy_in && (state_q == ISSUE) && wr_q;
  assign mem_dout = mem_wr ? wdata_q[8*int'(k_q) +: 8] : 8'h00;

  always_comb begin
    state_busy = '0;
    state_done = '0;
    if (state_q == ISSUE || state_q == DRAIN) state_busy[grant_q] = 1'b1;
    if (state_q == DONE) state_done[grant_q] = 1'b1;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdata
    assign r_data[i*32 +: 32] = rdata_q[i];
  end

endmodule

// File: tb/tb_mc_multiport.sv
// Bench for mc_multiport: directed and random transfers against a byte-array memory model,
// plus round-robin and fixed-priority arbitration checks on two instances.
module tb_mc_multiport;
  localparam int NP = 4;
  localparam int AW = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic [NP-1:0]    re = '0, we = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*32-1:0] w_data = '0;
  logic [NP*3-1:0]  len_in_byte = '0;
  logic [NP*32-1:0] r_data, fp_r_data;
  logic [NP-1:0]    state_busy, state_done, fp_busy, fp_done;
  logic [7:0]       mem_din = '0, mem_dout, fp_din = '0, fp_dout;
  logic [AW-1:0]    mem_a, fp_a;
  logic             mem_wr, fp_wr;

  logic [7:0] ram     [0:262143];
  logic [7:0] ref_mem [0:262143];
  int checks = 0, failures = 0;
  int model_ptr = NP - 1;

  mc_multiport #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_LEN(4), .ARB_MODE(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .re(re), .we(we), .addr(addr),
    .w_data(w_data), .len_in_byte(len_in_byte), .r_data(r_data), .state_busy(state_busy),
    .state_done(state_done), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr));

  mc_multiport #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_LEN(4), .ARB_MODE(0)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .re(re), .we(we), .addr(addr),
    .w_data(w_data), .len_in_byte(len_in_byte), .r_data(fp_r_data), .state_busy(fp_busy),
    .state_done(fp_done), .mem_din(fp_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr));

  always #5 clk_in = ~clk_in;

  // RAM with one-cycle read latency; only the round-robin instance may write.
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
    fp_din  <= ram[fp_a[17:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ram_ix(input logic [31:0] a, input int j);
    logic [31:0] s;
    s = a + 32'(j);
    return s[17:0];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input int n);
    logic [31:0] e;
    e = '0;
    for (int j = 0; j < n; j++) e[8*j +: 8] = ref_mem[ram_ix(a, j)];
    return e;
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] mask);
    for (int o = 1; o <= NP; o++) if (mask[(model_ptr + o) % NP]) return (model_ptr + o) % NP;
    return -1;
  endfunction

  function automatic int lowest(input logic [NP-1:0] mask);
    for (int i = 0; i < NP; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int len);
    re[p] = r;
    we[p] = w;
    addr[p*AW +: AW] = a;
    w_data[p*32 +: 32] = d;
    len_in_byte[p*3 +: 3] = 3'(len);
  endtask

  // One transfer on a single port, entered and left at a negedge with the DUT idle.
  task automatic run_xact(input int p, input bit wr, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input int len, input int freeze_at);
    int L, cyc, issued, exp_lat;
    bit got;
    logic [31:0] a0, ea;
    L = (len > 4) ? 4 : len;
    exp_lat = (L == 0) ? 1 : (wr ? L + 1 : L + 2);
    if (freeze_at > 0) exp_lat += 3;
    a0 = mem_a;
    cyc = 0; issued = 0; got = 0;
    set_port(p, !wr || both, wr, a, d, len);
    while (!got && cyc < 40) begin
      @(posedge clk_in);
      cyc++;
      @(negedge clk_in);
      rdy_in = !(freeze_at > 0 && cyc >= freeze_at && cyc < freeze_at + 3);
      #1;
      if (state_done != '0) got = 1;
      else if (!rdy_in) begin
        check("frozen_mem_wr", mem_wr, 0);
        check("frozen_mem_dout", mem_dout, 0);
      end else begin
        check("busy", state_busy, 1 << p);
        if (issued < L) begin
          ea = a + 32'(issued);
          check("mem_a", mem_a, ea);
          check("mem_wr", mem_wr, wr);
          if (wr) check("mem_dout", mem_dout, d[8*issued +: 8]);
          issued++;
        end
      end
    end
    check("done_seen", got, 1);
    check("latency", cyc, exp_lat);
    check("done_vec", state_done, 1 << p);
    check("busy_at_done", state_busy, 0);
    check("bytes_issued", issued, L);
    if (L == 0) check("len0_mem_a", mem_a, a0);
    re[p] = 1'b0;
    we[p] = 1'b0;
    model_ptr = p;
    if (wr) begin
      for (int j = 0; j < L; j++) ref_mem[ram_ix(a, j)] = d[8*j +: 8];
      for (int j = 0; j < L; j++) check("ram_byte", ram[ram_ix(a, j)], ref_mem[ram_ix(a, j)]);
    end else begin
      check("r_data", r_data[p*32 +: 32], exp_rdata(a, L));
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic arb_test(input int rounds);
    logic [NP-1:0] mask;
    logic [31:0] pa [NP];
    int cyc, ew, ef;
    for (int i = 0; i < NP; i++) begin
      pa[i] = $urandom;
      set_port(i, 0, 0, pa[i], 0, 1);
    end
    for (int r = 0; r < rounds; r++) begin
      mask = (r < 5) ? 4'hF : 4'($urandom_range(1, 15));
      re = mask;
      cyc = 0;
      do begin
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
      end while (state_done == '0 && cyc < 20);
      ew = rr_pick(mask);
      ef = lowest(mask);
      check("rr_grant", state_done, 1 << ew);
      check("fixed_grant", fp_done, 1 << ef);
      check("rr_rdata", r_data[ew*32 +: 32], {24'h0, ref_mem[ram_ix(pa[ew], 0)]});
      model_ptr = ew;
    end
    re = '0;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_r_data", r_data, 0);
    check("rst_busy", state_busy, 0);
    check("rst_done", state_done, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int j = 0; j < 4; j++) begin
      ram[18'h100 + j] = 8'(8'h11 * (j + 1));
      ref_mem[18'h100 + j] = ram[18'h100 + j];
    end
    run_xact(1, 0, 0, 32'h0000_0100, 32'h0, 4, 0);
    check("single_read_value", r_data[63:32], 32'h4433_2211);

    run_xact(2, 1, 0, 32'h0001_FFFC, 32'hAABB_CCDD, 2, 0);
    check("write_lo", ram[18'h1FFFC], 8'hDD);
    check("write_hi", ram[18'h1FFFD], 8'hCC);

    run_xact(0, 0, 0, $urandom, 32'h0, 3, 0);
    run_xact(3, 0, 0, $urandom, 32'h0, 0, 0);
    run_xact(2, 0, 0, $urandom, 32'h0, 7, 0);
    run_xact(0, 1, 0, 32'hFFFF_FFFE, $urandom, 4, 0);

    run_xact(1, 1, 0, 32'h0000_2000, 32'h1234_5678, 4, 2);
    run_xact(1, 0, 0, 32'h0000_2000, 32'h0, 4, 0);
    check("freeze_readback", r_data[63:32], 32'h1234_5678);

    for (int n = 0; n < 24; n++) begin
      bit wr, both;
      wr = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 3) == 0);
      run_xact($urandom_range(0, 3), wr, both, $urandom, $urandom, $urandom_range(0, 7), 0);
    end

    set_port(3, 1, 0, $urandom, 32'h0, 4);
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    check("busy_before_reset", state_busy, 4'b1000);
    rst_in = 1'b0;
    #1;
    check("midrst_r_data", r_data, 0);
    check("midrst_busy", state_busy, 0);
    check("midrst_done", state_done, 0);
    check("midrst_mem_a", mem_a, 0);
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_mem_dout", mem_dout, 0);
    re = '0;
    @(negedge clk_in);
    rst_in = 1'b1;
    model_ptr = NP - 1;
    arb_test(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
